// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared definitions for the RV32M multi-cycle sequencer.
// Holds funct3 op codes, FSM state encoding and op-decode helpers.
package ex_muldiv_ctrl_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic a_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV)  || (op == OP_REM);
    endfunction

    function automatic logic b_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_datapath.sv
// Radix-2 shift-add multiply / restoring divide datapath.
// Ports: clk_i, rst_i, load_i (capture operands), step_i (one
// iteration), op_i, a_i, b_i; res_o = result word after this edge.
module ex_muldiv_ctrl_datapath
    import ex_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] res_o
);

    // acc holds {hi, lo}: product for multiply, {remainder, quotient}
    // for divide. m is the addend / divisor magnitude.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [2:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic               negr_q, negr_d;

    logic               sa, sb, bz;
    logic [WIDTH-1:0]   ma, mb;
    logic [WIDTH-1:0]   hi, lo;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     t;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        sa = a_signed(op_i) & a_i[WIDTH-1];
        sb = b_signed(op_i) & b_i[WIDTH-1];
        ma = sa ? -a_i : a_i;
        mb = sb ? -b_i : b_i;
        bz = (b_i == '0);

        hi   = acc_q[2*WIDTH-1:WIDTH];
        lo   = acc_q[WIDTH-1:0];
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, m_q} : '0);
        t    = {hi, lo[WIDTH-1]};
        diff = {1'b0, t} - {2'b00, m_q};

        if (is_div(op_q)) begin
            if (!diff[WIDTH+1])
                acc_step = {diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
            else
                acc_step = {t[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
        end else begin
            acc_step = {sum, lo[WIDTH-1:1]};
        end

        acc_d  = acc_q;
        m_d    = m_q;
        op_d   = op_q;
        neg_d  = neg_q;
        negr_d = negr_q;
        if (load_i) begin
            op_d = op_i;
            if (is_div(op_i)) begin
                acc_d  = {{WIDTH{1'b0}}, ma};
                m_d    = mb;
                // x/0 quotient stays all ones regardless of sign
                neg_d  = (sa ^ sb) & ~bz;
                negr_d = sa;
            end else begin
                acc_d  = {{WIDTH{1'b0}}, mb};
                m_d    = ma;
                neg_d  = sa ^ sb;
                negr_d = 1'b0;
            end
        end else if (step_i) begin
            acc_d = acc_step;
        end

        // Result reflects the post-edge accumulator so the
        // controller can register it on the final step.
        prod = neg_q ? -acc_d : acc_d;
        quo  = neg_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
        rem  = negr_q ? -acc_d[2*WIDTH-1:WIDTH]
                      : acc_d[2*WIDTH-1:WIDTH];
        if (is_div(op_q))
            res_o = is_rem(op_q) ? rem : quo;
        else if (op_q == OP_MUL)
            res_o = prod[WIDTH-1:0];
        else
            res_o = prod[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q  <= '0;
            m_q    <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            negr_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            m_q    <= m_d;
            op_q   <= op_d;
            neg_q  <= neg_d;
            negr_q <= negr_d;
        end
    end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// RV32M multi-cycle sequencer beside the EX-stage ALU.
// Ports: clk, rst, start, op, a, b, flush, hold in;
// stall, done, result out.
module ex_muldiv_ctrl
    import ex_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit ZERO_FAST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hold,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;

    logic             accept;
    logic             fast;
    logic             load;
    logic             step;
    logic [WIDTH-1:0] zres;
    logic [WIDTH-1:0] dp_res;

    ex_muldiv_ctrl_datapath #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (load),
        .step_i (step),
        .op_i   (op),
        .a_i    (a),
        .b_i    (b),
        .res_o  (dp_res)
    );

    always_comb begin
        accept = (state_q == ST_IDLE) && start && !flush;
        fast   = accept && is_div(op) && (b == '0) && ZERO_FAST;
        zres   = is_rem(op) ? a : '1;

        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        stall   = 1'b0;
        load    = 1'b0;
        step    = 1'b0;

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            res_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        stall = 1'b1;
                        load  = 1'b1;
                        cnt_d = '0;
                        if (fast) begin
                            state_d = ST_DONE;
                            res_d   = zres;
                        end else begin
                            state_d = ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    stall = 1'b1;
                    step  = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                        res_d   = dp_res;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (!hold) begin
                        state_d = ST_IDLE;
                        res_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    res_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign done   = (state_q == ST_DONE);
    assign result = res_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed self-checking bench for ex_muldiv_ctrl.
// Hand-computed RV32M results, latency, stall, hold and flush.
module tb_ex_muldiv_ctrl;
    import ex_muldiv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        hold;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_muldiv_ctrl #(
        .WIDTH     (32),
        .ZERO_FAST (1'b1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .hold   (hold),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input int lat,
                          input int nhold);
        int   cyc;
        logic bad;
        cyc = 0;
        bad = 1'b0;
        @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        hold  = (nhold > 0);
        #1 check({tag, "_stall0"}, 32'(stall), 32'd1);
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (!done && !stall) bad = 1'b1;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(lat));
        check({tag, "_stall_busy"}, 32'(bad), 32'd0);
        check({tag, "_stall_done"}, 32'(stall), 32'd0);
        check({tag, "_res"}, result, exp);
        for (int k = 1; k <= nhold; k++) begin
            @(negedge clk);
            check({tag, "_hold_done"}, 32'(done), 32'd1);
            check({tag, "_hold_res"}, result, exp);
        end
        hold  = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check({tag, "_exit_done"}, 32'(done), 32'd0);
        check({tag, "_exit_res"}, result, 32'd0);
    endtask

    initial begin
        int   cyc;
        logic seen;
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        hold  = 1'b0;
        op    = OP_MUL;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res", result, 32'd0);
        rst = 1'b0;

        // reset asserted mid-BUSY
        @(negedge clk);
        op    = OP_MUL;
        a     = 32'd7;
        b     = 32'd3;
        start = 1'b1;
        repeat (5) @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("rstb_stall", 32'(stall), 32'd0);
        check("rstb_done", 32'(done), 32'd0);
        check("rstb_res", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstb_idle_stall", 32'(stall), 32'd0);
        check("rstb_idle_done", 32'(done), 32'd0);

        run_op("mul",    OP_MUL,    32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0);
        run_op("mulh",   OP_MULH,   32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, 0);
        run_op("mulhu",  OP_MULHU,  32'd7, 32'hFFFFFFFD, 32'h00000006, 33, 0);
        run_op("mulhsu", OP_MULHSU, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 33, 0);
        run_op("div",    OP_DIV,    32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 0);
        run_op("rem",    OP_REM,    32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 0);
        run_op("divu",   OP_DIVU,   32'd100, 32'd7, 32'd14, 33, 0);
        run_op("remu",   OP_REMU,   32'd100, 32'd7, 32'd2, 33, 0);
        run_op("div0",   OP_DIV,    32'd5, 32'd0, 32'hFFFFFFFF, 1, 0);
        run_op("rem0",   OP_REM,    32'd5, 32'd0, 32'd5, 1, 0);
        run_op("divu0",  OP_DIVU,   32'hFFFFFFF0, 32'd0, 32'hFFFFFFFF, 1, 0);
        run_op("remu0",  OP_REMU,   32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 1, 0);
        run_op("divov",  OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 0);
        run_op("remov",  OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0, 33, 0);
        run_op("hold",   OP_MUL,    32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 3);

        // flush in BUSY cycle 10
        @(negedge clk);
        op    = OP_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        start = 1'b0;
        #1 check("flb_stall", 32'(stall), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        check("flb_idle_done", 32'(done), 32'd0);
        check("flb_idle_stall", 32'(stall), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("flb_no_done", 32'(seen), 32'd0);
        run_op("flb_after", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);

        // flush while in DONE under hold
        @(negedge clk);
        op    = OP_MULHU;
        a     = 32'd7;
        b     = 32'hFFFFFFFD;
        start = 1'b1;
        hold  = 1'b1;
        cyc   = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("fld_done", 32'(done), 32'd1);
        check("fld_res", result, 32'd6);
        flush = 1'b1;
        start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        hold  = 1'b0;
        check("fld_exit_done", 32'(done), 32'd0);
        check("fld_exit_res", result, 32'd0);

        // flush and start together in IDLE: nothing accepted
        @(negedge clk);
        op    = OP_MUL;
        a     = 32'd3;
        b     = 32'd4;
        start = 1'b1;
        flush = 1'b1;
        #1 check("fls_stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        #1 check("fls_idle_stall", 32'(stall), 32'd0);
        check("fls_idle_done", 32'(done), 32'd0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
